// File: rtl/mc_path_collector_pkg.sv
// Shared types and default widths for the Monte Carlo path collector.
package mc_path_collector_pkg;

    localparam int LOG_T          = 9;
    localparam int ACC_W_DEF      = 18 + LOG_T;
    localparam int LOG_NPATHS_DEF = 10;
    localparam int SUM_W_DEF      = ACC_W_DEF + LOG_NPATHS_DEF;
    localparam int CNT_W_DEF      = LOG_NPATHS_DEF + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        ACCUM  = 3'd3,
        RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/mc_stats_update.sv
// Registered batch statistics: running sum, min, max and below-threshold count.
module mc_stats_update #(
    parameter int ACC_W = 27,
    parameter int SUM_W = 37,
    parameter int CNT_W = 11
) (
    input  logic             CLK,
    input  logic             iRSTn,
    input  logic             iClear,
    input  logic             iLoad,
    input  logic [ACC_W-1:0] iValue,
    input  logic [ACC_W-1:0] iThreshold,
    output logic [SUM_W-1:0] oSum,
    output logic [ACC_W-1:0] oMin,
    output logic [ACC_W-1:0] oMax,
    output logic [CNT_W-1:0] oBelow
);

    // Clear and reset share the same seed values so min/max start neutral.
    always_ff @(posedge CLK) begin
        if (!iRSTn || iClear) begin
            oSum   <= '0;
            oMin   <= '1;
            oMax   <= '0;
            oBelow <= '0;
        end else if (iLoad) begin
            oSum <= oSum + SUM_W'(iValue);
            if (iValue < oMin)
                oMin <= iValue;
            if (iValue > oMax)
                oMax <= iValue;
            if (iValue < iThreshold)
                oBelow <= oBelow + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_path_collector.sv
// Sequences a batch of paths through one Monte Carlo core and hands the
// batch statistics to the readout over a valid/ready handshake.
module mc_path_collector
    import mc_path_collector_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int NPATHS     = 1024,
    parameter int LOG_NPATHS = 10,
    parameter int TIMEOUT    = 2048
) (
    input  logic                       CLK,
    input  logic                       iRSTn,
    input  logic                       iRun,
    input  logic [ACC_W-1:0]           iThreshold,
    input  logic [ACC_W-1:0]           iCoreAcc,
    input  logic                       iCoreDone,
    output logic                       oCoreStart,
    output logic [ACC_W+LOG_NPATHS-1:0] oSum,
    output logic [ACC_W-1:0]           oMin,
    output logic [ACC_W-1:0]           oMax,
    output logic [LOG_NPATHS:0]        oBelow,
    output logic                       oError,
    output logic                       oValid,
    input  logic                       iReady,
    output logic                       oBusy
);

    localparam int SUM_W = ACC_W + LOG_NPATHS;
    localparam int CNT_W = LOG_NPATHS + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    state_t                  state, stateNext;
    logic [LOG_NPATHS-1:0]   pathCnt;
    logic [TO_W-1:0]         toCnt;
    logic [TO_W-1:0]         toNext;
    logic                    toExpire;
    logic                    lastPath;
    logic                    errorReg;
    logic                    statsClear;
    logic                    statsLoad;
    logic [ACC_W-1:0]        thresholdReg;
    logic [ACC_W-1:0]        coreAccP1;

    assign toNext   = toCnt + TO_W'(1);
    assign toExpire = (toNext == TO_W'(TIMEOUT - 1));
    assign lastPath = (pathCnt == LOG_NPATHS'(NPATHS - 1));

    always_ff @(posedge CLK) begin
        if (!iRSTn)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        statsClear = 1'b0;
        statsLoad  = 1'b0;
        case (state)
            IDLE: begin
                if (iRun) begin
                    stateNext  = START;
                    statsClear = 1'b1;
                end
            end
            START:  stateNext = WAIT;
            WAIT: begin
                if (iCoreDone)
                    stateNext = ACCUM;
                else if (toExpire)
                    stateNext = RESULT;
            end
            ACCUM: begin
                statsLoad = 1'b1;
                stateNext = lastPath ? RESULT : START;
            end
            RESULT: begin
                if (iReady)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!iRSTn) begin
            pathCnt  <= '0;
            toCnt    <= '0;
            errorReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iRun) begin
                        pathCnt  <= '0;
                        toCnt    <= '0;
                        errorReg <= 1'b0;
                    end
                end
                START: toCnt <= '0;
                WAIT: begin
                    if (!iCoreDone) begin
                        toCnt <= toNext;
                        if (toExpire)
                            errorReg <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (!lastPath)
                        pathCnt <= pathCnt + LOG_NPATHS'(1);
                end
                default: ;
            endcase
        end
    end

    // Capture stage: path sum held for the ACCUM cycle; threshold held per batch.
    always_ff @(posedge CLK) begin
        if (state == IDLE && iRun)
            thresholdReg <= iThreshold;
        if (state == WAIT && iCoreDone)
            coreAccP1 <= iCoreAcc;
    end

    mc_stats_update #(
        .ACC_W (ACC_W),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) uStats (
        .CLK        (CLK),
        .iRSTn      (iRSTn),
        .iClear     (statsClear),
        .iLoad      (statsLoad),
        .iValue     (coreAccP1),
        .iThreshold (thresholdReg),
        .oSum       (oSum),
        .oMin       (oMin),
        .oMax       (oMax),
        .oBelow     (oBelow)
    );

    assign oCoreStart = (state == START);
    assign oValid     = (state == RESULT);
    assign oBusy      = (state != IDLE);
    assign oError     = errorReg;

endmodule

// File: tb/tb_mc_path_collector.sv
// Bench for mc_path_collector: core responder model plus directed and random batches.
module tb_mc_path_collector;

    localparam int ACC_W      = 27;
    localparam int NPATHS     = 4;
    localparam int LOG_NPATHS = 2;
    localparam int TIMEOUT    = 16;
    localparam int SUM_W      = ACC_W + LOG_NPATHS;
    localparam int CNT_W      = LOG_NPATHS + 1;

    logic             CLK;
    logic             iRSTn;
    logic             iRun;
    logic [ACC_W-1:0] iThreshold;
    logic [ACC_W-1:0] iCoreAcc;
    logic             iCoreDone;
    logic             oCoreStart;
    logic [SUM_W-1:0] oSum;
    logic [ACC_W-1:0] oMin;
    logic [ACC_W-1:0] oMax;
    logic [CNT_W-1:0] oBelow;
    logic             oError;
    logic             oValid;
    logic             iReady;
    logic             oBusy;

    mc_path_collector #(
        .ACC_W      (ACC_W),
        .NPATHS     (NPATHS),
        .LOG_NPATHS (LOG_NPATHS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .iRSTn      (iRSTn),
        .iRun       (iRun),
        .iThreshold (iThreshold),
        .iCoreAcc   (iCoreAcc),
        .iCoreDone  (iCoreDone),
        .oCoreStart (oCoreStart),
        .oSum       (oSum),
        .oMin       (oMin),
        .oMax       (oMax),
        .oBelow     (oBelow),
        .oError     (oError),
        .oValid     (oValid),
        .iReady     (iReady),
        .oBusy      (oBusy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int nChecks = 0;
    int nFail   = 0;

    // Core model: answers each start strobe with one done pulse after a random delay.
    logic [ACC_W-1:0] pathVals[$];
    int               valIdx = 0;
    bit               coreSilent = 1'b0;
    bit               injectSpurious = 1'b0;
    int               startCyc[$];
    int               doneCyc[$];
    int               pend = -1;

    initial begin
        iCoreDone = 1'b0;
        iCoreAcc  = '0;
        forever begin
            @(posedge CLK);
            #1;
            iCoreDone = 1'b0;
            if (pend > 0)
                pend--;
            if (pend == 0) begin
                pend = -1;
                if (!coreSilent) begin
                    iCoreDone = 1'b1;
                    iCoreAcc  = (valIdx < pathVals.size()) ? pathVals[valIdx] : '0;
                    valIdx++;
                    doneCyc.push_back(cyc);
                end
            end
            if (oCoreStart === 1'b1) begin
                startCyc.push_back(cyc);
                pend = 1 + int'($urandom_range(0, 4));
                if (injectSpurious) begin
                    injectSpurious = 1'b0;
                    iCoreDone = 1'b1;
                    iCoreAcc  = 27'h5555555;
                end
            end
        end
    end

    logic [SUM_W-1:0] expSum;
    logic [ACC_W-1:0] expMin;
    logic [ACC_W-1:0] expMax;
    logic [CNT_W-1:0] expBelow;
    logic             expErr;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        assert (got === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference statistics computed directly from the list of path values.
    task automatic refModel(input logic [ACC_W-1:0] thr);
        longint unsigned s;
        longint unsigned mn;
        longint unsigned mx;
        int              b;
        s  = 0;
        mn = (64'd1 << ACC_W) - 1;
        mx = 0;
        b  = 0;
        for (int i = 0; i < NPATHS; i++) begin
            s += pathVals[i];
            if (pathVals[i] < mn) mn = pathVals[i];
            if (pathVals[i] > mx) mx = pathVals[i];
            if (pathVals[i] < thr) b++;
        end
        expSum   = SUM_W'(s);
        expMin   = ACC_W'(mn);
        expMax   = ACC_W'(mx);
        expBelow = CNT_W'(b);
        expErr   = 1'b0;
    endtask

    task automatic startBatch(input logic [ACC_W-1:0] thr);
        valIdx = 0;
        startCyc.delete();
        doneCyc.delete();
        iThreshold = thr;
        iRun = 1'b1;
        tick();
        iRun = 1'b0;
        iThreshold = ACC_W'($urandom);
    endtask

    task automatic waitValid(input int runPulseAt);
        int n;
        n = 0;
        while (oValid !== 1'b1 && n < 2000) begin
            iRun = (n == runPulseAt);
            tick();
            n++;
        end
        iRun = 1'b0;
        check("valid_reached", 64'(oValid), 64'(1));
    endtask

    task automatic checkResults(input string tag);
        check({tag, "_sum"},   64'(oSum),   64'(expSum));
        check({tag, "_min"},   64'(oMin),   64'(expMin));
        check({tag, "_max"},   64'(oMax),   64'(expMax));
        check({tag, "_below"}, 64'(oBelow), 64'(expBelow));
        check({tag, "_error"}, 64'(oError), 64'(expErr));
    endtask

    task automatic checkSpacing(input string tag);
        check({tag, "_starts"}, 64'(startCyc.size()), 64'(NPATHS));
        for (int k = 1; k < startCyc.size() && k <= doneCyc.size(); k++)
            check({tag, "_gap"}, 64'(startCyc[k] - doneCyc[k-1]), 64'(2));
    endtask

    task automatic releaseResult(input int holdCycles);
        for (int i = 0; i < holdCycles; i++) begin
            iReady = 1'b0;
            tick();
            check("hold_valid", 64'(oValid), 64'(1));
            checkResults("hold");
        end
        iReady = 1'b1;
        iRun   = 1'b1;
        tick();
        iReady = 1'b0;
        iRun   = 1'b0;
        check("drop_valid", 64'(oValid), 64'(0));
        check("idle_busy",  64'(oBusy),  64'(0));
        tick();
        check("no_restart", 64'(oBusy), 64'(0));
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_busy"},  64'(oBusy),      64'(0));
        check({tag, "_valid"}, 64'(oValid),     64'(0));
        check({tag, "_start"}, 64'(oCoreStart), 64'(0));
        check({tag, "_err"},   64'(oError),     64'(0));
        check({tag, "_sum"},   64'(oSum),       64'(0));
        check({tag, "_min"},   64'(oMin),       64'((64'd1 << ACC_W) - 1));
        check({tag, "_max"},   64'(oMax),       64'(0));
        check({tag, "_below"}, 64'(oBelow),     64'(0));
    endtask

    initial begin
        int s;
        int starts;
        int n;
        logic [ACC_W-1:0] thr;

        iRSTn = 1'b0;
        iRun = 1'b0;
        iReady = 1'b0;
        iThreshold = '0;
        repeat (3) tick();
        checkResetState("reset");
        iRSTn = 1'b1;
        tick();

        // Directed batch with a 10-cycle hold, then a same-cycle iRun on release.
        pathVals = '{27'd100, 27'd50, 27'd300, 27'd200};
        refModel(27'd150);
        check("ref_sum_650", 64'(expSum), 64'(650));
        startBatch(27'd150);
        waitValid(-1);
        checkResults("basic");
        checkSpacing("basic");
        releaseResult(10);

        // Path values equal to the threshold are not counted.
        pathVals = '{27'd150, 27'd149, 27'd151, 27'd150};
        refModel(27'd150);
        startBatch(27'd150);
        waitValid(-1);
        checkResults("equal");
        releaseResult(1);

        // Silent core: timeout after 16 cycles, statistics untouched.
        coreSilent = 1'b1;
        startBatch(27'd1000);
        check("to_start", 64'(oCoreStart), 64'(1));
        s = cyc;
        waitValid(-1);
        check("to_latency", 64'(cyc - s), 64'(TIMEOUT));
        expSum = '0; expMin = '1; expMax = '0; expBelow = '0; expErr = 1'b1;
        checkResults("timeout");
        releaseResult(2);
        coreSilent = 1'b0;

        // Mid-batch iRun and a spurious done during START change nothing.
        pathVals = '{27'd100, 27'd50, 27'd300, 27'd200};
        refModel(27'd150);
        injectSpurious = 1'b1;
        startBatch(27'd150);
        waitValid(5);
        checkResults("disturb");
        checkSpacing("disturb");
        releaseResult(0);

        // Reset while waiting on path 2, then a fresh full batch.
        pathVals.delete();
        for (int i = 0; i < NPATHS; i++) pathVals.push_back(ACC_W'($urandom));
        startBatch(27'd5000000);
        starts = 1;
        n = 0;
        while (starts < 2 && n < 200) begin
            tick();
            n++;
            if (oCoreStart === 1'b1) starts++;
        end
        check("rst_reach_path2", 64'(starts), 64'(2));
        tick();
        iRSTn = 1'b0;
        tick();
        iRSTn = 1'b1;
        checkResetState("midrst");
        repeat (10) tick();
        check("midrst_idle", 64'(oBusy), 64'(0));
        thr = ACC_W'($urandom);
        refModel(thr);
        startBatch(thr);
        waitValid(-1);
        checkResults("after_rst");
        checkSpacing("after_rst");
        releaseResult(1);

        // Random batches; the first has iReady high before RESULT is entered.
        for (int it = 0; it < 6; it++) begin
            thr = ACC_W'($urandom);
            pathVals.delete();
            for (int i = 0; i < NPATHS; i++)
                pathVals.push_back(($urandom_range(0, 3) == 0) ? thr : ACC_W'($urandom));
            refModel(thr);
            iReady = (it == 0);
            startBatch(thr);
            waitValid(-1);
            checkResults("rand");
            checkSpacing("rand");
            if (it == 0) begin
                tick();
                iReady = 1'b0;
                check("ready_early_one_cycle", 64'(oValid), 64'(0));
                tick();
            end else begin
                releaseResult(int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
